// File: rtl/mem_power_sequencer.sv
// ---------------------------------------------------------------------------
// mem_power_sequencer
//
// Sequences a core and its memory macro into and out of a low-power sleep
// state. Entry stops instruction fetch, waits for the core to go idle,
// gates the core clock, puts the memory into retention and, for deep
// sleep, opens the large and then the small power switch. Wake-up walks
// the same ladder in reverse. Each timed step has a programmable dwell.
//
// Parameters
//   CNT_W             width of the dwell counter and dwell configuration
//
// Ports
//   clk_i             core-domain clock, rising edge
//   HRESETn           asynchronous active-low reset
//   sleep_req_i       one-cycle sleep request, honoured only in RUN
//   deep_i            sleep depth captured with an accepted request
//                     (1 = open power switches, 0 = retention only)
//   wake_i            level wake source
//   core_busy_i       core still executing; entry waits while high
//   cfg_t_down_i      power-down step dwell minus one
//   cfg_t_up_i        power-up step dwell minus one
//   fetch_en_o        core fetch enable
//   clk_gate_core_o   core clock enable (1 = running)
//   mem_sleep_o       memory retention pin (1 = retention)
//   mem_gate_small_o  small power switch (1 = closed / powered)
//   mem_gate_large_o  large power switch (1 = closed / powered)
//   sleeping_o        high only while asleep
//   busy_o            high while moving between RUN and SLEEP
// ---------------------------------------------------------------------------
module mem_power_sequencer #(
    parameter int CNT_W = 8
) (
    input  logic             clk_i,
    input  logic             HRESETn,
    input  logic             sleep_req_i,
    input  logic             deep_i,
    input  logic             wake_i,
    input  logic             core_busy_i,
    input  logic [CNT_W-1:0] cfg_t_down_i,
    input  logic [CNT_W-1:0] cfg_t_up_i,
    output logic             fetch_en_o,
    output logic             clk_gate_core_o,
    output logic             mem_sleep_o,
    output logic             mem_gate_small_o,
    output logic             mem_gate_large_o,
    output logic             sleeping_o,
    output logic             busy_o
);

    typedef enum logic [3:0] {
        RUN,
        DRAIN,
        CLK_OFF,
        MEM_RET,
        GATE_L,
        GATE_S,
        SLEEP,
        UNGATE_S,
        UNGATE_L,
        MEM_WAKE,
        CLK_ON
    } state_e;

    // Output vector order: fetch_en, clk_gate, mem_sleep, gate_small, gate_large
    localparam logic [4:0] OutRun     = 5'b11011;
    localparam logic [4:0] OutDrain   = 5'b01011;
    localparam logic [4:0] OutClkOff  = 5'b00011;
    localparam logic [4:0] OutMemRet  = 5'b00111;
    localparam logic [4:0] OutGateL   = 5'b00110;
    localparam logic [4:0] OutGateS   = 5'b00100;

    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    state_e            state_q, state_d;
    logic              deep_q, deep_d;
    logic [CNT_W-1:0]  dwellCnt_q, dwellCnt_d;
    logic [4:0]        pwrOut_q, pwrOut_d;
    logic              sleeping_q, sleeping_d;
    logic              busy_q, busy_d;
    logic              dwellDone;

    assign dwellDone = (dwellCnt_q == '0);

    // Next state, dwell counter and registered-output decode.
    // Outputs are decoded from the next state so that the output flops
    // always reflect the state register they are clocked alongside.
    always_comb begin
        state_d    = state_q;
        deep_d     = deep_q;
        dwellCnt_d = dwellCnt_q;
        pwrOut_d   = OutRun;
        sleeping_d = 1'b0;
        busy_d     = 1'b0;

        case (state_q)
            RUN: begin
                if (sleep_req_i && !wake_i) begin
                    state_d = DRAIN;
                    deep_d  = deep_i;
                end
            end
            // Wake wins over idle so a pending irq aborts the entry.
            DRAIN: begin
                if (wake_i) begin
                    state_d = RUN;
                end else if (!core_busy_i) begin
                    state_d = CLK_OFF;
                end
            end
            CLK_OFF: state_d = MEM_RET;
            // Wake at the end of a power-down dwell turns back through the
            // mirror state instead of going deeper.
            MEM_RET: begin
                if (dwellDone) begin
                    if (wake_i) begin
                        state_d = MEM_WAKE;
                    end else if (deep_q) begin
                        state_d = GATE_L;
                    end else begin
                        state_d = SLEEP;
                    end
                end
            end
            GATE_L: begin
                if (dwellDone) begin
                    state_d = wake_i ? UNGATE_L : GATE_S;
                end
            end
            GATE_S: begin
                if (dwellDone) begin
                    state_d = wake_i ? UNGATE_S : SLEEP;
                end
            end
            SLEEP: begin
                if (wake_i) begin
                    state_d = deep_q ? UNGATE_S : MEM_WAKE;
                end
            end
            UNGATE_S: if (dwellDone) state_d = UNGATE_L;
            UNGATE_L: if (dwellDone) state_d = MEM_WAKE;
            MEM_WAKE: if (dwellDone) state_d = CLK_ON;
            CLK_ON:   state_d = RUN;
            default:  state_d = RUN;
        endcase

        // The dwell is captured on entry, so later cfg changes cannot
        // stretch or shorten a dwell already in progress.
        if (state_d != state_q) begin
            case (state_d)
                MEM_RET, GATE_L, GATE_S:     dwellCnt_d = cfg_t_down_i;
                UNGATE_S, UNGATE_L, MEM_WAKE: dwellCnt_d = cfg_t_up_i;
                default:                     dwellCnt_d = '0;
            endcase
        end else if (!dwellDone) begin
            dwellCnt_d = dwellCnt_q - CntOne;
        end

        // Power-up states reuse the power-down encodings one rung higher,
        // which keeps the small switch closing before the large one.
        case (state_d)
            RUN:      pwrOut_d = OutRun;
            DRAIN:    pwrOut_d = OutDrain;
            CLK_OFF:  pwrOut_d = OutClkOff;
            MEM_RET:  pwrOut_d = OutMemRet;
            GATE_L:   pwrOut_d = OutGateL;
            GATE_S:   pwrOut_d = OutGateS;
            SLEEP:    pwrOut_d = deep_d ? OutGateS : OutMemRet;
            UNGATE_S: pwrOut_d = OutGateL;
            UNGATE_L: pwrOut_d = OutMemRet;
            MEM_WAKE: pwrOut_d = OutClkOff;
            CLK_ON:   pwrOut_d = OutDrain;
            default:  pwrOut_d = OutRun;
        endcase

        sleeping_d = (state_d == SLEEP);
        busy_d     = (state_d != RUN) && (state_d != SLEEP);
    end

    // State and output registers; reset forces the RUN outputs at once,
    // even from SLEEP with switches open.
    always_ff @(posedge clk_i or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q    <= RUN;
            deep_q     <= 1'b0;
            dwellCnt_q <= '0;
            pwrOut_q   <= OutRun;
            sleeping_q <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            deep_q     <= deep_d;
            dwellCnt_q <= dwellCnt_d;
            pwrOut_q   <= pwrOut_d;
            sleeping_q <= sleeping_d;
            busy_q     <= busy_d;
        end
    end

    assign fetch_en_o       = pwrOut_q[4];
    assign clk_gate_core_o  = pwrOut_q[3];
    assign mem_sleep_o      = pwrOut_q[2];
    assign mem_gate_small_o = pwrOut_q[1];
    assign mem_gate_large_o = pwrOut_q[0];
    assign sleeping_o       = sleeping_q;
    assign busy_o           = busy_q;

endmodule

// File: tb/tb_mem_power_sequencer.sv
// ---------------------------------------------------------------------------
// tb_mem_power_sequencer
//
// Bench for mem_power_sequencer. The reference model treats the sequence
// as a ladder of power levels (0 = RUN ... 5 = both switches open) walked
// down on entry and up on wake; each level has one output pattern, so the
// power-up states fall out as "one rung above" their mirror. Directed
// scenarios pin the model with hand-computed timings, then a randomized
// phase compares DUT and model on every falling edge.
// ---------------------------------------------------------------------------
module tb_mem_power_sequencer;

    localparam int CNT_W = 8;

    logic             clk_i        = 1'b0;
    logic             HRESETn      = 1'b0;
    logic             sleep_req_i  = 1'b0;
    logic             deep_i       = 1'b0;
    logic             wake_i       = 1'b0;
    logic             core_busy_i  = 1'b0;
    logic [CNT_W-1:0] cfg_t_down_i = '0;
    logic [CNT_W-1:0] cfg_t_up_i   = '0;
    logic             fetch_en_o;
    logic             clk_gate_core_o;
    logic             mem_sleep_o;
    logic             mem_gate_small_o;
    logic             mem_gate_large_o;
    logic             sleeping_o;
    logic             busy_o;

    int checkCount = 0;
    int passCount  = 0;

    // Ladder model state
    int mLevel;
    bit mUp;
    bit mAsleep;
    bit mDeep;
    int mElapsed;
    int mLen;

    mem_power_sequencer #(.CNT_W(CNT_W)) dut (
        .clk_i            (clk_i),
        .HRESETn          (HRESETn),
        .sleep_req_i      (sleep_req_i),
        .deep_i           (deep_i),
        .wake_i           (wake_i),
        .core_busy_i      (core_busy_i),
        .cfg_t_down_i     (cfg_t_down_i),
        .cfg_t_up_i       (cfg_t_up_i),
        .fetch_en_o       (fetch_en_o),
        .clk_gate_core_o  (clk_gate_core_o),
        .mem_sleep_o      (mem_sleep_o),
        .mem_gate_small_o (mem_gate_small_o),
        .mem_gate_large_o (mem_gate_large_o),
        .sleeping_o       (sleeping_o),
        .busy_o           (busy_o)
    );

    initial forever #5 clk_i = ~clk_i;

    // Expected {fetch, clk, mem_sleep, small, large, sleeping, busy}
    function automatic logic [6:0] modelOut();
        logic [4:0] pwr;
        case (mLevel)
            0:       pwr = 5'b11011;
            1:       pwr = 5'b01011;
            2:       pwr = 5'b00011;
            3:       pwr = 5'b00111;
            4:       pwr = 5'b00110;
            default: pwr = 5'b00100;
        endcase
        return {pwr, mAsleep, (mLevel != 0) && !mAsleep};
    endfunction

    task automatic modelReset();
        mLevel   = 0;
        mUp      = 1'b0;
        mAsleep  = 1'b0;
        mDeep    = 1'b0;
        mElapsed = 0;
        mLen     = 0;
    endtask

    task automatic enterDwell(input int len);
        mElapsed = 1;
        mLen     = len;
    endtask

    // One rising edge of the ladder, using the inputs seen at that edge.
    task automatic modelStep();
        if (!HRESETn) begin
            modelReset();
        end else if (mAsleep) begin
            if (wake_i) begin
                mAsleep = 1'b0;
                mUp     = 1'b1;
                mLevel  = mLevel - 1;
                enterDwell(int'(cfg_t_up_i) + 1);
            end
        end else if (mLevel == 0) begin
            if (sleep_req_i && !wake_i) begin
                mLevel = 1;
                mUp    = 1'b0;
                mDeep  = deep_i;
            end
        end else if (!mUp && mLevel == 1) begin
            if (wake_i) begin
                mLevel = 0;
            end else if (!core_busy_i) begin
                mLevel = 2;
                enterDwell(1);
            end
        end else if (mElapsed < mLen) begin
            mElapsed++;
        end else if (mUp) begin
            mLevel = mLevel - 1;
            if (mLevel == 1) enterDwell(1);
            else if (mLevel >= 2) enterDwell(int'(cfg_t_up_i) + 1);
            else mUp = 1'b0;
        end else if (mLevel >= 3 && wake_i) begin
            mUp    = 1'b1;
            mLevel = mLevel - 1;
            enterDwell(int'(cfg_t_up_i) + 1);
        end else if (mLevel == (mDeep ? 5 : 3)) begin
            mAsleep = 1'b1;
        end else begin
            mLevel = mLevel + 1;
            enterDwell(int'(cfg_t_down_i) + 1);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        modelStep();
        #1;
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic checkOutput();
        logic [6:0] act;
        logic [6:0] exp;
        act = {fetch_en_o, clk_gate_core_o, mem_sleep_o, mem_gate_small_o,
               mem_gate_large_o, sleeping_o, busy_o};
        exp = modelOut();
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL model_compare t=%0t actual=%b expected=%b", $time, act, exp);
    endtask

    task automatic checkLit(input string name, input logic act, input logic exp);
        checkCount++;
        if (act === exp) passCount++;
        else $display("[TB] FAIL %s t=%0t actual=%b expected=%b", name, $time, act, exp);
    endtask

    task automatic pulseReq(input logic d);
        sleep_req_i = 1'b1;
        deep_i      = d;
        tick();
        sleep_req_i = 1'b0;
    endtask

    // Continuous comparison against the model on every falling edge.
    initial begin
        #1;
        forever begin
            @(negedge clk_i);
            checkOutput();
        end
    end

    task automatic applyStimulus();
        // Reset and the first cycle after release
        modelReset();
        ticks(3);
        checkLit("rst_fetch", fetch_en_o, 1'b1);
        checkLit("rst_gl", mem_gate_large_o, 1'b1);
        checkLit("rst_busy", busy_o, 1'b0);
        HRESETn = 1'b1;
        tick();
        checkLit("rel_fetch", fetch_en_o, 1'b1);
        checkLit("rel_msleep", mem_sleep_o, 1'b0);

        // Retention sleep, cfg_down=3
        cfg_t_down_i = 8'd3;
        cfg_t_up_i   = 8'd1;
        pulseReq(1'b0);
        checkLit("ret_fetch_c1", fetch_en_o, 1'b0);
        checkLit("ret_clk_c1", clk_gate_core_o, 1'b1);
        tick();
        checkLit("ret_clk_c2", clk_gate_core_o, 1'b0);
        tick();
        checkLit("ret_msleep_c3", mem_sleep_o, 1'b1);
        ticks(3);
        checkLit("ret_sleeping_c6", sleeping_o, 1'b0);
        tick();
        checkLit("ret_sleeping_c7", sleeping_o, 1'b1);
        checkLit("ret_gs_c7", mem_gate_small_o, 1'b1);
        checkLit("ret_gl_c7", mem_gate_large_o, 1'b1);
        checkLit("model_asleep_c7", mAsleep, 1'b1);
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        checkLit("ret_wake_msleep", mem_sleep_o, 1'b0);
        ticks(3);
        checkLit("ret_back_fetch", fetch_en_o, 1'b1);

        // Deep sleep and wake, cfg_down=0, cfg_up=2
        cfg_t_down_i = 8'd0;
        cfg_t_up_i   = 8'd2;
        pulseReq(1'b1);
        ticks(3);
        checkLit("deep_gl_c4", mem_gate_large_o, 1'b0);
        checkLit("deep_gs_c4", mem_gate_small_o, 1'b1);
        tick();
        checkLit("deep_gs_c5", mem_gate_small_o, 1'b0);
        tick();
        checkLit("deep_sleeping_c6", sleeping_o, 1'b1);
        checkLit("model_level_c6", (mLevel == 5), 1'b1);
        ticks(2);
        wake_i = 1'b1;
        tick();
        wake_i = 1'b0;
        checkLit("up_gs_w1", mem_gate_small_o, 1'b1);
        checkLit("up_gl_w1", mem_gate_large_o, 1'b0);
        ticks(2);
        checkLit("up_gl_w3", mem_gate_large_o, 1'b0);
        tick();
        checkLit("up_gl_w4", mem_gate_large_o, 1'b1);
        ticks(2);
        checkLit("up_msleep_w6", mem_sleep_o, 1'b1);
        tick();
        checkLit("up_msleep_w7", mem_sleep_o, 1'b0);
        ticks(2);
        checkLit("up_clk_w9", clk_gate_core_o, 1'b0);
        tick();
        checkLit("up_clk_w10", clk_gate_core_o, 1'b1);
        checkLit("up_fetch_w10", fetch_en_o, 1'b0);
        tick();
        checkLit("up_fetch_w11", fetch_en_o, 1'b1);

        // Drain hold then abort by wake
        core_busy_i = 1'b1;
        pulseReq(1'b0);
        checkLit("drain_busy", busy_o, 1'b1);
        for (int i = 0; i < 10; i++) begin
            checkLit("drain_clk", clk_gate_core_o, 1'b1);
            tick();
        end
        wake_i = 1'b1;
        tick();
        checkLit("abort_fetch", fetch_en_o, 1'b1);
        checkLit("abort_msleep", mem_sleep_o, 1'b0);
        checkLit("abort_busy", busy_o, 1'b0);
        wake_i      = 1'b0;
        core_busy_i = 1'b0;
        tick();

        // Wake during GATE_L, cfg_down=3, cfg_up=1
        cfg_t_down_i = 8'd3;
        cfg_t_up_i   = 8'd1;
        pulseReq(1'b1);
        ticks(6);
        checkLit("gl_gl_c7", mem_gate_large_o, 1'b0);
        checkLit("gl_gs_c7", mem_gate_small_o, 1'b1);
        wake_i = 1'b1;
        ticks(4);
        checkLit("mirror_gs_c11", mem_gate_small_o, 1'b1);
        checkLit("mirror_gl_c11", mem_gate_large_o, 1'b1);
        checkLit("mirror_msleep_c11", mem_sleep_o, 1'b1);
        ticks(2);
        checkLit("mirror_msleep_c13", mem_sleep_o, 1'b0);
        ticks(3);
        checkLit("mirror_fetch_c16", fetch_en_o, 1'b1);
        checkLit("mirror_busy_c16", busy_o, 1'b0);
        wake_i = 1'b0;
        tick();

        // Asynchronous reset from deep sleep
        cfg_t_down_i = 8'd0;
        pulseReq(1'b1);
        ticks(5);
        checkLit("pre_rst_sleeping", sleeping_o, 1'b1);
        checkLit("pre_rst_gs", mem_gate_small_o, 1'b0);
        #2;
        HRESETn = 1'b0;
        modelReset();
        #1;
        checkLit("arst_fetch", fetch_en_o, 1'b1);
        checkLit("arst_clk", clk_gate_core_o, 1'b1);
        checkLit("arst_msleep", mem_sleep_o, 1'b0);
        checkLit("arst_gs", mem_gate_small_o, 1'b1);
        checkLit("arst_gl", mem_gate_large_o, 1'b1);
        checkLit("arst_sleeping", sleeping_o, 1'b0);
        checkLit("arst_busy", busy_o, 1'b0);
        tick();
        HRESETn = 1'b1;
        tick();
        checkLit("arst_rel_fetch", fetch_en_o, 1'b1);

        // Request ignored while wake is high
        wake_i      = 1'b1;
        sleep_req_i = 1'b1;
        tick();
        sleep_req_i = 1'b0;
        checkLit("ign_busy", busy_o, 1'b0);
        checkLit("ign_fetch", fetch_en_o, 1'b1);
        tick();
        checkLit("ign_busy2", busy_o, 1'b0);
        wake_i = 1'b0;

        // Randomized traffic, compared every cycle against the ladder model
        for (int i = 0; i < 4000; i++) begin
            sleep_req_i = ($urandom_range(0, 5) == 0);
            deep_i      = 1'($urandom_range(0, 1));
            core_busy_i = ($urandom_range(0, 2) == 0);
            if (wake_i) wake_i = ($urandom_range(0, 3) != 0);
            else        wake_i = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 19) == 0) cfg_t_down_i = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 19) == 0) cfg_t_up_i   = CNT_W'($urandom_range(0, 4));
            if ($urandom_range(0, 799) == 0) begin
                #2;
                HRESETn = 1'b0;
                modelReset();
                #1;
                checkOutput();
                ticks(2);
                HRESETn = 1'b1;
            end
            tick();
        end
    endtask

    initial begin
        applyStimulus();
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/mem_power_sequencer.md
MEM_POWER_SEQUENCER -- requirements
Module: mem_power_sequencer

Interface
REQ-001 Parameter: CNT_W, default 8, width of dwell counters and dwell configuration inputs.
REQ-002 clk_i  input  1  core-domain clock; all state changes on the rising edge.
REQ-003 HRESETn  input  1  reset, asynchronous, active-low.
REQ-004 sleep_req_i  input  1  single-cycle strobe requesting sleep entry; honoured only in RUN.
REQ-005 deep_i  input  1  sleep depth; 1 means deep sleep with switches open, 0 means retention only; sampled with an accepted sleep_req_i.
REQ-006 wake_i  input  1  level wake source, from the OR of pending irqs and events.
REQ-007 core_busy_i  input  1  core still executing; sleep entry waits while this is 1.
REQ-008 cfg_t_down_i  input  CNT_W  power-down dwell configuration; each power-down step lasts cfg_t_down_i+1 cycles.
REQ-009 cfg_t_up_i  input  CNT_W  power-up dwell configuration; each power-up step lasts cfg_t_up_i+1 cycles.
REQ-010 fetch_en_o  output  1  core fetch enable.
REQ-011 clk_gate_core_o  output  1  core clock enable; 1 means clock running.
REQ-012 mem_sleep_o  output  1  memory retention (sleep pin); 1 means memory in retention.
REQ-013 mem_gate_small_o  output  1  small power switch; 1 means closed (powered).
REQ-014 mem_gate_large_o  output  1  large power switch; 1 means closed (powered).
REQ-015 sleeping_o  output  1  1 only in state SLEEP.
REQ-016 busy_o  output  1  1 in every state except RUN and SLEEP.

Function
REQ-017 The sequencer SHALL use these states: RUN, DRAIN, CLK_OFF, MEM_RET, GATE_L, GATE_S, SLEEP, UNGATE_S, UNGATE_L, MEM_WAKE and CLK_ON.
REQ-018 All outputs SHALL be registered, and each SHALL be a pure function of the current state.
REQ-019 Output values per state, in the order fetch_en, clk_gate, mem_sleep, gate_small, gate_large:
  - RUN = 1,1,0,1,1
  - DRAIN = 0,1,0,1,1
  - CLK_OFF = 0,0,0,1,1
  - MEM_RET = 0,0,1,1,1
  - GATE_L = 0,0,1,1,0
  - GATE_S = 0,0,1,0,0
  - SLEEP = the same values as the last power-down state reached
  - UNGATE_S = 0,0,1,1,0
  - UNGATE_L = 0,0,1,1,1
  - MEM_WAKE = 0,0,0,1,1
  - CLK_ON = 0,1,0,1,1
REQ-020 RUN SHALL go to DRAIN in the cycle after sleep_req_i=1 is seen with wake_i=0, and deep_i SHALL be latched into a deep flag in that same cycle.
REQ-021 RUN SHALL ignore sleep_req_i while wake_i=1, and sleep_req_i in any other state SHALL be dropped (not queued).
REQ-022 DRAIN SHALL go to CLK_OFF in the first cycle with core_busy_i=0 and wake_i=0, and SHALL return to RUN if wake_i=1 (wake takes priority over idle).
REQ-023 CLK_OFF SHALL last 1 cycle and then go to MEM_RET.
REQ-024 The down-counter SHALL be loaded on entry to each timed state: with cfg_t_down_i on entry to MEM_RET, GATE_L and GATE_S, and with cfg_t_up_i on entry to UNGATE_S, UNGATE_L and MEM_WAKE.
REQ-025 A timed state SHALL exit in the cycle after the counter reads 0, giving a dwell of cfg+1 cycles; cfg changes during a dwell SHALL have no effect on that dwell.
REQ-026 The power-down path at dwell end:
  - MEM_RET goes to GATE_L if deep=1, otherwise to SLEEP
  - GATE_L goes to GATE_S
  - GATE_S goes to SLEEP
REQ-027 If wake_i=1 at dwell end of a power-down state, that state SHALL go to its mirror instead of advancing:
  - MEM_RET goes to MEM_WAKE
  - GATE_L goes to UNGATE_L
  - GATE_S goes to UNGATE_S
REQ-028 SLEEP SHALL go to UNGATE_S the cycle after wake_i=1 if deep=1, and to MEM_WAKE if deep=0.
REQ-029 The power-up path at dwell end: UNGATE_S goes to UNGATE_L, UNGATE_L goes to MEM_WAKE, and MEM_WAKE goes to CLK_ON; wake_i SHALL be ignored during power-up.
REQ-030 CLK_ON SHALL last 1 cycle and then go to RUN, so the clock runs one cycle before fetch_en_o rises.
REQ-031 The switches SHALL obey strict ordering: gate_small opens only after gate_large is open, closes before gate_large closes, and mem_sleep_o=1 whenever either switch is open.

Reset
REQ-032 While HRESETn=0, and in the first cycle after its release, the state SHALL be RUN with outputs fetch_en=1, clk_gate=1, mem_sleep=0, gate_small=1, gate_large=1, sleeping=0, busy=0.
REQ-033 While HRESETn=0, the deep flag SHALL be 0 and the counter SHALL be 0.
REQ-034 Reset asserted mid-sequence, including SLEEP with switches open, SHALL force the RUN outputs immediately (asynchronously), without stepping through the sequence.

Verification
REQ-035 Retention sleep:
  - stimulus: cfg_t_down_i=3, deep_i=0, core_busy_i=0, sleep_req_i pulse at cycle 0
  - response: fetch_en_o=0 at cycle 1, clk_gate_core_o=0 at cycle 2, mem_sleep_o=1 at cycle 3, sleeping_o=1 at cycle 7, switches stay 1 throughout
REQ-036 Deep sleep and wake:
  - stimulus: cfg_t_down_i=0, cfg_t_up_i=2, deep_i=1; then wake_i=1 while in SLEEP
  - response: gate_large_o falls one cycle before gate_small_o on the way down; on wake, gate_small_o rises, then gate_large_o 3 cycles later, mem_sleep_o falls 3 cycles after that, clk_gate_core_o rises next, fetch_en_o rises 1 cycle later
REQ-037 Drain hold and abort:
  - stimulus: core_busy_i=1 for 10 cycles after sleep_req_i; then repeat with wake_i=1 during DRAIN
  - response: the sequencer stays in DRAIN with clk_gate_core_o=1; in the wake_i=1 case it is back in RUN one cycle later, with fetch_en_o=1 and mem_sleep_o never asserted
REQ-038 Wake during power-down:
  - stimulus: wake_i=1 during GATE_L, deep_i=1
  - response: gate_small_o never falls; the next state is UNGATE_L, then MEM_WAKE, then RUN
REQ-039 Reset in deep sleep:
  - stimulus: HRESETn=0 asserted while in SLEEP with deep=1
  - response: all outputs take their RUN values asynchronously, before the next clock edge
REQ-040 Ignored request: sleep_req_i pulsed together with wake_i=1 -> the sequencer stays in RUN and busy_o stays 0.
